pipe_divider: RTL and testbench
===============================

PIPE_DIVIDER -- requirements
Module: pipe_divider

Interface
REQ-001 SHALL have parameter N, default 16, dividend and quotient width (N >= 2).
REQ-002 SHALL have parameter M, default 8, divisor and remainder width (1 <= M <= N).
REQ-003 SHALL have parameter TAG_W, default 4, sideband tag width carried alongside each operation.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand pair present.
REQ-007 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-008 SHALL have port dividend  input  N  dividend.
REQ-009 SHALL have port divisor  input  M  divisor.
REQ-010 SHALL have port in_tag  input  TAG_W  sideband tag.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port quotient  output  N  quotient.
REQ-014 SHALL have port remainder  output  M  remainder.
REQ-015 SHALL have port div0  output  1  divisor was zero for this result.
REQ-016 SHALL have port out_tag  output  TAG_W  tag of this result.

Function
REQ-017 SHALL compute restoring division: N pipeline stages; stage k resolves quotient bit N-1-k with an (M+1)-bit partial remainder compare/subtract.
REQ-018 SHALL accept an operation on any cycle where in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready); pipeline advances as a whole when in_ready is 1, holds every stage including valid bits otherwise.
REQ-020 SHALL have latency exactly N cycles from accept to out_valid with no stall; throughput one op per cycle.
REQ-021 SHALL propagate stage valid bits as bubbles; an empty stage never asserts out_valid.
REQ-022 SHALL keep quotient, remainder, div0, out_tag stable while out_valid && !out_ready.
REQ-023 SHALL, for divisor == 0, output quotient = all ones, remainder = dividend[M-1:0], div0 = 1; otherwise div0 = 0.
REQ-024 SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every nonzero divisor, unsigned.
REQ-025 SHALL drive quotient, remainder, div0, out_tag to 0 whenever out_valid is 0.

Reset
REQ-026 SHALL, on rst high at a clock edge, clear all stage valid bits and data registers; out_valid, quotient, remainder, div0, out_tag = 0; in_ready = 1 the cycle after.
REQ-027 SHALL discard all in-flight operations on reset mid-operation; none emerge afterwards.
REQ-028 SHALL ignore in_valid during a cycle in which rst is high.

Configuration
REQ-029 SHALL, with macro PIPE_DIVIDER_SIGNED_EN defined, treat dividend and divisor as two's complement: absolute values enter the pipeline, one extra output stage applies signs (quotient negative iff operand signs differ, remainder takes dividend sign), latency N+1.
REQ-030 SHALL, with PIPE_DIVIDER_SIGNED_EN defined, for divisor == 0 output quotient = all ones, remainder = dividend[M-1:0], div0 = 1, no sign fix.
REQ-031 SHALL, without PIPE_DIVIDER_SIGNED_EN, be purely unsigned with latency N and no sign logic instantiated.

Structure
REQ-032 SHALL place latency constant function, default widths and the per-stage payload struct (partial remainder, quotient so far, residual dividend bits, divisor, tag, div0, signs) in package pipe_divider_pkg.
REQ-033 SHALL implement one stage as sub-module pipe_divider_stage, instantiated N times by generate loop, each with a shared advance enable.

Verification
REQ-034 SHALL cover: N=16,M=8, dividend 1000, divisor 7, tag 3 -> after 16 cycles quotient 142, remainder 6, div0 0, out_tag 3.
REQ-035 SHALL cover: divisor 0, dividend 0x1234 -> quotient 0xFFFF, remainder 0x34, div0 1.
REQ-036 SHALL cover: 20 back-to-back ops, out_ready low for cycles 18-22 -> in_ready low for exactly those held cycles, results in order, none lost or duplicated, outputs stable while held.
REQ-037 SHALL cover: rst pulsed with 5 ops in flight -> out_valid stays 0 until a new op is accepted, then that result alone arrives N cycles later.
REQ-038 SHALL cover: PIPE_DIVIDER_SIGNED_EN, dividend -100, divisor 7 -> after 17 cycles quotient -14, remainder -2.
REQ-039 SHALL cover: 10000 random unsigned operand pairs against a reference model -> every result matches REQ-023/REQ-024.

Source files
------------

// File: rtl/pipe_divider_pkg.sv
// Shared widths, latency helper and stage payload layout for pipe_divider.
// Optional build macro: PIPE_DIVIDER_SIGNED_EN adds the sign-fix output stage.
package pipe_divider_pkg;

  localparam int unsigned DEF_N     = 16;
  localparam int unsigned DEF_M     = 8;
  localparam int unsigned DEF_TAG_W = 4;

  // Per-stage payload; the top builds the same layout at its own widths.
  typedef struct packed {
    logic [DEF_M-1:0]     rem;
    logic [DEF_N-1:0]     quo;
    logic [DEF_N-1:0]     dvd;
    logic [DEF_M-1:0]     dsr;
    logic [DEF_TAG_W-1:0] tag;
    logic                 div0;
    logic                 neg_q;
    logic                 neg_r;
  } payload_t;

  function automatic int unsigned latency(input int unsigned n);
`ifdef PIPE_DIVIDER_SIGNED_EN
    return n + 1;
`else
    return n;
`endif
  endfunction

endpackage

// File: rtl/pipe_divider_stage.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, record the quotient bit. Registered, held when adv_i is low.
module pipe_divider_stage
  import pipe_divider_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned M = DEF_M,
  parameter type payload_t = pipe_divider_pkg::payload_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     adv_i,
  input  logic     vld_i,
  input  payload_t p_i,
  output logic     vld_o,
  output payload_t p_o
);

  logic [M:0] trial;
  logic [M:0] diff;
  logic       fits;
  logic       vld_q;
  payload_t   p_d;
  payload_t   p_q;

  // diff[M] is the borrow of the trial subtract; a zero divisor always "fits"
  // so the quotient fills with ones and the remainder carries dividend bits.
  always_comb begin
    trial   = {p_i.rem, p_i.dvd[N-1]};
    diff    = trial - {1'b0, p_i.dsr};
    fits    = ~diff[M] | p_i.div0;
    p_d     = p_i;
    p_d.rem = fits ? diff[M-1:0] : trial[M-1:0];
    p_d.quo = {p_i.quo[N-2:0], fits};
    p_d.dvd = {p_i.dvd[N-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      p_q   <= '0;
    end else if (adv_i) begin
      vld_q <= vld_i;
      p_q   <= p_d;
    end
  end

  assign vld_o = vld_q;
  assign p_o   = p_q;

endmodule

// File: rtl/pipe_divider.sv
// N-stage pipelined restoring divider with tag sideband and global stall.
// Define PIPE_DIVIDER_SIGNED_EN for two's-complement operands (latency N+1).
module pipe_divider
  import pipe_divider_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned M     = DEF_M,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     dividend,
  input  logic [M-1:0]     divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     quotient,
  output logic [M-1:0]     remainder,
  output logic             div0,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [M-1:0]     rem;
    logic [N-1:0]     quo;
    logic [N-1:0]     dvd;
    logic [M-1:0]     dsr;
    logic [TAG_W-1:0] tag;
    logic             div0;
    logic             neg_q;
    logic             neg_r;
  } link_t;

  logic [N:0] vld;
  link_t      pl [N+1];
  link_t      in_p;

  assign in_ready = !(out_valid && !out_ready);

  always_comb begin
    in_p      = '0;
    in_p.dvd  = dividend;
    in_p.dsr  = divisor;
    in_p.tag  = in_tag;
    in_p.div0 = (divisor == '0);
`ifdef PIPE_DIVIDER_SIGNED_EN
    // Zero divisor keeps the raw dividend so the remainder is its low bits.
    if (!in_p.div0) begin
      in_p.dvd   = dividend[N-1] ? -dividend : dividend;
      in_p.dsr   = divisor[M-1] ? -divisor : divisor;
      in_p.neg_q = dividend[N-1] ^ divisor[M-1];
      in_p.neg_r = dividend[N-1];
    end
`endif
  end

  assign vld[0] = in_valid;
  assign pl[0]  = in_p;

  for (genvar k = 0; k < N; k++) begin : g_stage
    pipe_divider_stage #(
      .N        (N),
      .M        (M),
      .payload_t(link_t)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .adv_i(in_ready),
      .vld_i(vld[k]),
      .p_i  (pl[k]),
      .vld_o(vld[k+1]),
      .p_o  (pl[k+1])
    );
  end

`ifdef PIPE_DIVIDER_SIGNED_EN
  logic             vld_q;
  logic [N-1:0]     quo_q, quo_d;
  logic [M-1:0]     rem_q, rem_d;
  logic             div0_q;
  logic [TAG_W-1:0] tag_q;

  always_comb begin
    quo_d = pl[N].neg_q ? -pl[N].quo : pl[N].quo;
    rem_d = pl[N].neg_r ? -pl[N].rem : pl[N].rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      div0_q <= 1'b0;
      tag_q  <= '0;
    end else if (in_ready) begin
      vld_q  <= vld[N];
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      div0_q <= pl[N].div0;
      tag_q  <= pl[N].tag;
    end
  end

  assign out_valid = vld_q;
  assign quotient  = vld_q ? quo_q : '0;
  assign remainder = vld_q ? rem_q : '0;
  assign div0      = vld_q & div0_q;
  assign out_tag   = vld_q ? tag_q : '0;
`else
  assign out_valid = vld[N];
  assign quotient  = vld[N] ? pl[N].quo : '0;
  assign remainder = vld[N] ? pl[N].rem : '0;
  assign div0      = vld[N] & pl[N].div0;
  assign out_tag   = vld[N] ? pl[N].tag : '0;
`endif

endmodule

// File: tb/tb_pipe_divider.sv
// Self-checking bench for pipe_divider: directed cases plus randomized traffic
// against an arithmetic reference model and an in-order expected-result queue.
module tb_pipe_divider;
  import pipe_divider_pkg::*;

  localparam int N   = 16;
  localparam int M   = 8;
  localparam int TW  = 4;
  localparam int LAT = int'(latency(N));

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  dividend = '0;
  logic [M-1:0]  divisor = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  quotient;
  logic [M-1:0]  remainder;
  logic          div0;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  pipe_divider #(.N(N), .M(M), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div0(div0), .out_tag(out_tag)
  );

  typedef struct {
    logic [N-1:0]  q;
    logic [M-1:0]  r;
    logic          d0;
    logic [TW-1:0] t;
    int            acc;
    int            snap;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  int          low_cnt = 0;
  int          ord_mode = 0;
  int          win_lo = 0;
  int          win_hi = 0;
  logic        prev_held = 1'b0;
  logic [28:0] prev_out = '0;
  exp_t        e;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference: plain arithmetic from the division rules.
  function automatic void model(input logic [N-1:0] a, input logic [M-1:0] b,
                                output logic [N-1:0] q, output logic [M-1:0] r,
                                output logic d0);
    int sa, sb;
    if (b == '0) begin
      q = '1; r = a[M-1:0]; d0 = 1'b1;
    end else begin
`ifdef PIPE_DIVIDER_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      q  = N'(sa / sb);
      r  = M'(sa % sb);
`else
      sa = int'(a);
      sb = int'(b);
      q  = N'(sa / sb);
      r  = M'(sa % sb);
`endif
      d0 = 1'b0;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ord_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = !(cyc >= win_lo && cyc <= win_hi);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_held = 1'b0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (!out_valid) begin
        check("idle_zero", {quotient, remainder, div0, out_tag}, '0);
      end else begin
        if (prev_held)
          check("held_stable", {quotient, remainder, div0, out_tag}, prev_out);
        else if (exp_q.size() == 0)
          check("spurious_out_valid", out_valid, 1'b0);
        else
          check("latency", cyc, exp_q[0].acc + LAT + stall_cnt - exp_q[0].snap);
        if (out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div0", div0, e.d0);
          check("out_tag", out_tag, e.t);
        end
      end
      prev_held = out_valid && !out_ready;
      prev_out  = {quotient, remainder, div0, out_tag};
      if (!in_ready) begin
        stall_cnt++;
        low_cnt++;
      end
      if (in_valid && in_ready) begin
        model(dividend, divisor, e.q, e.r, e.d0);
        e.t    = in_tag;
        e.acc  = cyc;
        e.snap = stall_cnt;
        exp_q.push_back(e);
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] a, input logic [M-1:0] b,
                      input logic [TW-1:0] t, output int acc);
    int w;
    w = 0;
    in_valid = 1'b1; dividend = a; divisor = b; in_tag = t;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", in_ready, 1'b1);
    acc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string nm, input int acc, input logic [N-1:0] q,
                               input logic [M-1:0] r, input logic d0, input logic [TW-1:0] t);
    int w;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 4 * LAT) begin
      w++;
      @(negedge clk);
    end
    check({nm, "_lat"}, cyc - acc, LAT);
    check({nm, "_q"}, quotient, q);
    check({nm, "_r"}, remainder, r);
    check({nm, "_div0"}, div0, d0);
    check({nm, "_tag"}, out_tag, t);
    align();
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 20 * LAT) begin
      @(negedge clk);
      w++;
    end
    check({nm, "_drained"}, exp_q.size(), 0);
    align();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, cmp=%0d err=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] mq;
    logic [M-1:0] mr;
    logic         md;
    int           acc;
    int           cnt;

    model(16'd1000, 8'd7, mq, mr, md);
    check("pin_q_1000_7", {mq, mr, md}, {16'd142, 8'd6, 1'b0});
    model(16'h1234, 8'd0, mq, mr, md);
    check("pin_div0", {mq, mr, md}, {16'hFFFF, 8'h34, 1'b1});
`ifdef PIPE_DIVIDER_SIGNED_EN
    model(16'hFF9C, 8'd7, mq, mr, md);
    check("pin_signed", {mq, mr, md}, {16'hFFF2, 8'hFE, 1'b0});
`else
    model(16'hFFFF, 8'hFF, mq, mr, md);
    check("pin_ffff_ff", {mq, mr, md}, {16'd257, 8'd0, 1'b0});
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", {quotient, remainder, div0, out_tag}, '0);
    check("rst_in_ready", in_ready, 1'b1);
    align();

    send(16'd1000, 8'd7, 4'd3, acc);
    expect_result("basic", acc, 16'd142, 8'd6, 1'b0, 4'd3);
    send(16'h1234, 8'd0, 4'd5, acc);
    expect_result("zero_div", acc, 16'hFFFF, 8'h34, 1'b1, 4'd5);
`ifdef PIPE_DIVIDER_SIGNED_EN
    send(16'hFF9C, 8'd7, 4'd1, acc);
    expect_result("signed", acc, 16'hFFF2, 8'hFE, 1'b0, 4'd1);
`endif
    drain("directed");

    // Back-to-back burst with out_ready low for relative cycles 18..22.
    low_cnt  = 0;
    win_lo   = cyc + 19;
    win_hi   = cyc + 23;
    ord_mode = 1;
    align();
    for (int i = 0; i < 20; i++)
      send(N'(1000 * i + 37), M'(i + 1), TW'(i), acc);
    drain("burst");
    check("burst_in_ready_low_cycles", low_cnt, 5);
    ord_mode = 0;

    // Reset with five operations in flight.
    for (int i = 0; i < 5; i++)
      send(N'(500 + i), 8'd3, TW'(i), acc);
    rst = 1'b1;
    align();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    cnt = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("rst_no_ghost", cnt, 0);
    align();
    send(16'd77, 8'd5, 4'd9, acc);
    expect_result("post_rst", acc, 16'd15, 8'd2, 1'b0, 4'd9);
    drain("post_rst");

    ord_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      logic [M-1:0] b;
      int           sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = '0;
      else if (sel < 4)  b = M'($urandom_range(1, 3));
      else               b = M'($urandom);
      if ($urandom_range(0, 3) == 0) align();
      send(N'($urandom), b, TW'($urandom), acc);
    end
    ord_mode = 0;
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
